// File: rtl/pip_skid_reg.sv
// Generic pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, synchronous flush-to-bubble and a saturating squashed-entry counter.
module pip_skid_reg #(
    parameter int unsigned             DATA_WIDTH  = 96,
    parameter int unsigned             CTRL_WIDTH  = 12,
    parameter logic [CTRL_WIDTH-1:0]   CTRL_BUBBLE = '0,
    parameter int unsigned             CNT_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [CTRL_WIDTH-1:0] up_ctrl_i,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [CTRL_WIDTH-1:0] dn_ctrl_o,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  squashed_o
);

    // Two spare bits let occupancy (up to 2) be added without overflowing.
    localparam int unsigned           SUM_WIDTH = CNT_WIDTH + 2;
    localparam logic [SUM_WIDTH-1:0]  CNT_MAX   = SUM_WIDTH'({CNT_WIDTH{1'b1}});

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [CTRL_WIDTH-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0]  main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [CNT_WIDTH-1:0]   squashed_q,  squashed_d;

    logic                   up_xfer;
    logic                   dn_xfer;
    logic [SUM_WIDTH-1:0]   squash_add;
    logic [SUM_WIDTH-1:0]   squash_sum;

    // Outputs decode straight from registered state; ready never sees dn_ready_i.
    assign dn_valid_o  = (state_q != ST_EMPTY);
    assign up_ready_o  = (state_q != ST_TWO);
    assign occupancy_o = 2'(state_q);
    assign dn_ctrl_o   = main_ctrl_q;
    assign dn_data_o   = main_data_q;
    assign squashed_o  = squashed_q;

    assign up_xfer = up_valid_i & up_ready_o;
    assign dn_xfer = dn_valid_o & dn_ready_i;

    // Entries lost to a flush: everything held, minus what leaves, plus what arrives.
    assign squash_add = SUM_WIDTH'(occupancy_o) - SUM_WIDTH'(dn_xfer) + SUM_WIDTH'(up_xfer);
    assign squash_sum = SUM_WIDTH'(squashed_q) + squash_add;

    // Next-state and datapath steering; flush has priority over handshakes.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        squashed_d  = squashed_q;

        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
            main_data_d = '0;
            squashed_d  = (squash_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0]
                                                 : squash_sum[CNT_WIDTH-1:0];
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = up_ctrl_i;
                        main_data_d = up_data_i;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_ctrl_d = up_ctrl_i;
                        main_data_d = up_data_i;
                    end else if (up_xfer) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = up_ctrl_i;
                        skid_data_d = up_data_i;
                    end else if (dn_xfer) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = CTRL_BUBBLE;
                        main_data_d = '0;
                    end
                end
                ST_TWO: begin
                    if (dn_xfer) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = CTRL_BUBBLE;
                    main_data_d = '0;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            squashed_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            squashed_q  <= squashed_d;
        end
    end

endmodule

// File: tb/tb_pip_skid_reg.sv
// Bench for pip_skid_reg: queue-based reference model with a negedge monitor.
module tb_pip_skid_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 12;
    localparam int unsigned NW = 2;
    localparam logic [CW-1:0] BUBBLE = 12'hB0B;
    localparam int SQ_MAX = 3;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          up_valid;
    logic          up_ready;
    logic [CW-1:0] up_ctrl;
    logic [DW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [CW-1:0] dn_ctrl;
    logic [DW-1:0] dn_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] squashed;

    int   n_checks;
    int   n_pass;
    bit   armed;
    ent_t held[$];
    int   sq_model;

    pip_skid_reg #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .CTRL_BUBBLE(BUBBLE),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .up_valid_i (up_valid),
        .up_ready_o (up_ready),
        .up_ctrl_i  (up_ctrl),
        .up_data_i  (up_data),
        .dn_valid_o (dn_valid),
        .dn_ready_i (dn_ready),
        .dn_ctrl_o  (dn_ctrl),
        .dn_data_o  (dn_data),
        .occupancy_o(occupancy),
        .squashed_o (squashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: the stage is a 2-deep FIFO; entries enter when it holds
    // fewer than two and leave from the front when downstream is ready.
    always @(posedge clk) begin : model
        int occ;
        bit dx;
        bit ux;
        ent_t e;
        if (rst) begin
            held.delete();
            sq_model = 0;
            armed    = 1'b1;
        end else if (armed) begin
            occ = held.size();
            dx  = (occ > 0) && dn_ready;
            ux  = up_valid && (occ < 2);
            if (flush) begin
                sq_model = sq_model + occ - int'(dx) + int'(ux);
                if (sq_model > SQ_MAX) sq_model = SQ_MAX;
                held.delete();
            end else begin
                if (dx) void'(held.pop_front());
                if (ux) begin
                    e.c = up_ctrl;
                    e.d = up_data;
                    held.push_back(e);
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            check("dn_valid", 128'(dn_valid), 128'(held.size() > 0));
            check("up_ready", 128'(up_ready), 128'(held.size() < 2));
            check("occupancy", 128'(occupancy), 128'(held.size()));
            check("squashed", 128'(squashed), 128'(sq_model));
            if (held.size() > 0) begin
                check("dn_ctrl", 128'(dn_ctrl), 128'(held[0].c));
                check("dn_data", 128'(dn_data), 128'(held[0].d));
            end else begin
                check("bubble_ctrl", 128'(dn_ctrl), 128'(BUBBLE));
                check("bubble_data", 128'(dn_data), 128'(0));
            end
        end
    end

    task automatic cyc(input bit r, input bit f, input bit uv, input logic [CW-1:0] uc,
                       input logic [DW-1:0] ud, input bit dr);
        @(negedge clk);
        #1;
        rst      = r;
        flush    = f;
        up_valid = uv;
        up_ctrl  = uc;
        up_data  = ud;
        dn_ready = dr;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        armed    = 1'b0;
        sq_model = 0;
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_ctrl = '0; up_data = '0; dn_ready = 1'b0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Stream of four with downstream always ready
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, CW'(i + 1), DW'(8'hA0 + i), 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Fill the skid buffer, then drain
        cyc(0, 0, 1, 12'h011, DW'(8'h11), 0);
        cyc(0, 0, 1, 12'h022, DW'(8'h22), 0);
        cyc(0, 0, 1, 12'h033, DW'(8'h33), 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Flush with two held and downstream stalled
        cyc(0, 0, 1, 12'h044, DW'(8'h44), 0);
        cyc(0, 0, 1, 12'h055, DW'(8'h55), 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset, then flush with one held plus DX and UX in the same cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 12'h066, DW'(8'h66), 0);
        cyc(0, 1, 1, 12'h077, DW'(8'h77), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Saturation: five flushes each squashing one entry
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, CW'(12'h100 + i), DW'(i), 0);
            cyc(0, 1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);

        // Reset overrides flush with two held
        cyc(0, 0, 1, 12'h0AA, DW'(8'hAA), 0);
        cyc(0, 0, 1, 12'h0BB, DW'(8'hBB), 0);
        cyc(1, 1, 1, 12'h0CC, DW'(8'hCC), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) < 7), CW'($urandom),
                {$urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 6));
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pip_skid_reg.md
Name: pip_skid_reg

Overview:
- Parametrised successor to the fixed decode-to-execute pipeline register.
- Generic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so stalls propagate without a combinational ready path.
- Synchronous flush turns the stage into a bubble and counts squashed instructions.
- Instanced between any two pipeline stages (F/D, D/E, E/M, M/W) with per-stage widths.

Parameters:
- DATA_WIDTH, 96, width of payload bus (operands, PC, immediates, register addresses).
- CTRL_WIDTH, 12, width of control bus (RegWrite, MemWrite, Jump, Branch, ALU control, ...).
- CTRL_BUBBLE, {CTRL_WIDTH{1'b0}}, control value presented while the stage holds a bubble.
- CNT_WIDTH, 8, width of the squashed-entry counter.

Ports:
- clk_i  in  1  clock; one clock, all state updates on posedge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  squash all held entries, synchronous.
- up_valid_i  in  1  upstream presents an entry.
- up_ready_o  out  1  stage can accept an entry.
- up_ctrl_i  in  CTRL_WIDTH  upstream control.
- up_data_i  in  DATA_WIDTH  upstream payload.
- dn_valid_o  out  1  stage presents an entry.
- dn_ready_i  in  1  downstream accepts.
- dn_ctrl_o  out  CTRL_WIDTH  control to next stage.
- dn_data_o  out  DATA_WIDTH  payload to next stage.
- occupancy_o  out  2  entries held: 0, 1 or 2.
- squashed_o  out  CNT_WIDTH  saturating count of entries discarded by flush.

Behaviour:
- Handshake definitions:
  - Up transfer (UX) = up_valid_i & up_ready_o.
  - Down transfer (DX) = dn_valid_o & dn_ready_i.
  - A held entry may not change while dn_valid_o=1 and dn_ready_i=0.
- Storage:
  - Main register (drives dn_*) plus a skid register.
  - States: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- Output decoding:
  - dn_valid_o = (state != EMPTY).
  - up_ready_o = (state != TWO), decoded from state only; there is no combinational path from dn_ready_i.
  - In EMPTY, dn_ctrl_o = CTRL_BUBBLE and dn_data_o = 0.
- Transitions (flush_i=0):
  - EMPTY: UX -> ONE, main<=up. Otherwise stay.
  - ONE: UX & DX -> ONE, main<=up. UX only -> TWO, skid<=up. DX only -> EMPTY, main<=bubble. Neither -> stay.
  - TWO: UX impossible. DX -> ONE, main<=skid. Otherwise stay.
- Latency and throughput:
  - 1 cycle from UX to dn_valid_o.
  - Sustains 1 entry/cycle when dn_ready_i is held high.
  - Ordering is FIFO.
- Flush (flush_i=1), priority over all else:
  - Next state is EMPTY; main is set to bubble (ctrl=CTRL_BUBBLE, data=0).
  - A DX in the same cycle counts as consumed (not squashed).
  - A UX in the same cycle is accepted and then discarded (squashed).
  - squashed_o += occupancy - DX + UX, saturating at 2^CNT_WIDTH-1.
  - up_ready_o=1 in the cycle after the flush.
- Reset (rst_i=1):
  - Next cycle: EMPTY, dn_valid_o=0, dn_ctrl_o=CTRL_BUBBLE, dn_data_o=0, up_ready_o=1, occupancy_o=0, squashed_o=0.
  - Reset overrides flush and all handshakes.
  - Reset mid-transfer drops all entries without counting them.
- Control and payload travel together; there is no partial update of either field.
- Ready for the flush-bubble logic that was left incomplete in earlier stage registers; this block replaces that behaviour.

Test Plan:
- Reset then stream of 4 entries (ctrl 1..4, data 0xA0..0xA3) with dn_ready_i=1 -> dn outputs 1..4 on consecutive cycles, each one cycle after acceptance; occupancy_o stays at 1 and up_ready_o never drops.
- Push 0x11 and 0x22 with dn_ready_i=0 -> occupancy_o=2 and up_ready_o=0. Raise dn_ready_i -> 0x11 then 0x22 out; up_ready_o=1 the cycle after the first DX.
- occupancy 2 and flush_i=1 with dn_ready_i=0 -> next cycle dn_valid_o=0, dn_ctrl_o=CTRL_BUBBLE, dn_data_o=0, squashed_o=2.
- occupancy 1, same cycle: flush_i=1, DX and UX -> squashed_o increments by 1 (the incoming entry); the DX entry is not counted.
- CNT_WIDTH=2 with 5 flushes each squashing one entry -> squashed_o saturates at 3.
- rst_i asserted with occupancy 2 and flush_i=1 -> next cycle all outputs at reset values, squashed_o=0.
